// File: rtl/bcd_display_pkg.sv
// Shared definitions for the BCD display converter.
//   - FSM state encodings (IDLE / SHIFT / DONE)
//   - Active-low 7-segment patterns, bit0 = a .. bit6 = g
//   - add3: double-dabble digit correction
//   - pow10: elaboration-time power of ten, used for the overflow threshold
package bcd_display_pkg;

    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t SHIFT = 2'd1;
    localparam state_t DONE  = 2'd2;

    // Index 0 is the leftmost element because the range ascends.
    localparam logic [0:9][6:0] SEG_DIGIT = {
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_ZERO = 7'b1000000;

    // A digit >= 5 would become >= 10 after the next shift; adding 3 first
    // makes the shift carry into the next digit instead.
    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

endpackage

// File: rtl/bcd_display_converter_seg7.sv
// Combinational 7-segment encoder for one BCD digit.
//   digit : 4-bit BCD value
//   dash  : force the dash pattern (overflow indication)
//   seg   : active-low segments, bit0 = a .. bit6 = g
// Non-decimal codes (10..15) also show a dash.
module seg7_digit_encoder
    import bcd_display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       dash,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        if (!dash && digit <= 4'd9) seg = SEG_DIGIT[digit];
    end

endmodule

// File: rtl/bcd_display_converter.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock)
// with registered 7-segment outputs.
//   clk, n_reset : clock, synchronous active-low reset
//   start        : request a conversion; honoured in IDLE or DONE only
//   binary       : unsigned input, latched when start is accepted
//   busy         : high while shifting
//   done         : one-cycle pulse, outputs freshly updated
//   overflow     : converted value did not fit in DIGITS decimal digits
//   bcd          : packed BCD, digit 0 (ones) in bits [3:0]
//   ones..thousands : active-low segment patterns for digits 0..3
// Outputs only change on the edge that enters DONE, so the displays keep
// the previous result while a new conversion is in flight.
// The four named segment ports assume DIGITS >= 4.
module bcd_display_converter
    import bcd_display_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      binary,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [6:0]            ones,
    output logic [6:0]            tens,
    output logic [6:0]            hundreds,
    output logic [6:0]            thousands
);

    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

    state_t                   state;
    logic [WIDTH-1:0]         shreg;
    logic [SW-1:0]            scratch;
    logic [CW-1:0]            cnt;
    logic                     ovf_pend;

    logic [SW-1:0]            corr;
    logic [SW-1:0]            scr_nx;
    logic [WIDTH-1:0]         sh_nx;
    logic [DIGITS-1:0][6:0]   seg_nx;
    logic [DIGITS-1:0][6:0]   seg_q;
    logic [SW-1:0]            bcd_q;
    logic                     ovf_q;

    // Correct then shift; the bit leaving the top digit is dropped, which
    // leaves the low DIGITS digits of the true decimal value.
    always_comb begin
        corr = '0;
        for (int i = 0; i < DIGITS; i++) corr[4*i +: 4] = add3(scratch[4*i +: 4]);
        {scr_nx, sh_nx} = {corr, shreg} << 1;
    end

    // Encoders look at the post-shift scratch so the final shift's result
    // is captured on the same edge that enters DONE.
    for (genvar g = 0; g < DIGITS; g++) begin : g_enc
        seg7_digit_encoder u_enc (
            .digit (scr_nx[4*g +: 4]),
            .dash  (ovf_pend),
            .seg   (seg_nx[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state    <= IDLE;
            shreg    <= '0;
            scratch  <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
            seg_q    <= {DIGITS{SEG_ZERO}};
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        shreg    <= binary;
                        scratch  <= '0;
                        cnt      <= '0;
                        ovf_pend <= (64'(binary) > MAX_VAL);
                        state    <= SHIFT;
                    end else begin
                        state    <= IDLE;
                    end
                end
                SHIFT: begin
                    scratch <= scr_nx;
                    shreg   <= sh_nx;
                    cnt     <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= DONE;
                        bcd_q <= scr_nx;
                        seg_q <= seg_nx;
                        ovf_q <= ovf_pend;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state == SHIFT);
    assign done      = (state == DONE);
    assign overflow  = ovf_q;
    assign bcd       = bcd_q;
    assign ones      = seg_q[0];
    assign tens      = seg_q[1];
    assign hundreds  = seg_q[2];
    assign thousands = seg_q[3];

endmodule
